// File: rtl/cache_pkg.sv
// Shared types and derived geometry for the two-way
// set-associative data cache.
package cache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t WRITEBACK = 2'd1;
  localparam state_t FETCH     = 2'd2;
  localparam state_t REFILL    = 2'd3;

  function automatic int tag_w(
    input int addr_w,
    input int index_w,
    input int offset_w
  );
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int blk_w(
    input int word_w,
    input int offset_w
  );
    return word_w << offset_w;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid, dirty, tag and block per set,
// with a lookup port and a word-merge / full-refill write port.
module cache_way #(
  parameter int INDEX_W  = 2,
  parameter int TAG_W    = 4,
  parameter int OFFSET_W = 2,
  parameter int WORD_W   = 8,
  parameter int BLK_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic                match_o,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [BLK_W-1:0]    block_o,
  input  logic                wr_en,
  input  logic                wr_fill,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [WORD_W-1:0]   wr_word,
  input  logic [BLK_W-1:0]    wr_block
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [TAG_W-1:0] tag_d [SETS];
  logic [BLK_W-1:0] blk_q [SETS];
  logic [BLK_W-1:0] blk_d [SETS];

  assign valid_o = valid_q[rd_index];
  assign dirty_o = dirty_q[rd_index];
  assign tag_o   = tag_q[rd_index];
  assign block_o = blk_q[rd_index];
  assign match_o = valid_o && (tag_o == rd_tag);

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    blk_d   = blk_q;
    if (wr_en) begin
      if (wr_fill) begin
        valid_d[wr_index] = 1'b1;
        dirty_d[wr_index] = 1'b0;
        tag_d[wr_index]   = wr_tag;
        blk_d[wr_index]   = wr_block;
      end else begin
        dirty_d[wr_index] = 1'b1;
        blk_d[wr_index][wr_offset*WORD_W +: WORD_W] = wr_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_q[s] <= '0;
        blk_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      blk_q   <= blk_d;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Two-way set-associative write-back cache: FSM, per-set LRU,
// victim selection and saturating hit/miss counters.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 2,
  parameter int CNT_W    = 16,
  localparam int TAG_W   = tag_w(ADDR_W, INDEX_W, OFFSET_W),
  localparam int BLK_W   = blk_w(WORD_W, OFFSET_W)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     READ_CPU,
  input  logic                     WRITE_CPU,
  input  logic [ADDR_W-1:0]        cpu_address,
  input  logic [WORD_W-1:0]        WRITEDATA_CPU,
  output logic [WORD_W-1:0]        READDATA_CPU,
  output logic                     busywait_cpu,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAG_W+INDEX_W-1:0] mem_block_address,
  output logic [BLK_W-1:0]         mem_WriteData,
  input  logic [BLK_W-1:0]         mem_ReadData,
  input  logic                     mem_busywait,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);

  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [OFFSET_W-1:0] cpu_off;

  state_t             state_q, state_d;
  logic [SETS-1:0]    lru_q, lru_d;
  logic               victim_q, victim_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [INDEX_W-1:0] req_index_q, req_index_d;
  logic [BLK_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [1:0]         match, vld, drt, way_we;
  logic [TAG_W-1:0]   way_tag [2];
  logic [BLK_W-1:0]   way_blk [2];
  logic               way_fill;
  logic [INDEX_W-1:0] lk_index, wr_index;
  logic [BLK_W-1:0]   sel_blk;
  logic               req, hit, hit_way, idle;

  assign cpu_tag   = cpu_address[ADDR_W-1 -: TAG_W];
  assign cpu_index = cpu_address[OFFSET_W +: INDEX_W];
  assign cpu_off   = cpu_address[OFFSET_W-1:0];

  assign idle     = (state_q == IDLE);
  assign lk_index = idle ? cpu_index : req_index_q;
  assign req      = READ_CPU | WRITE_CPU;
  assign hit      = match[0] ^ match[1];
  assign hit_way  = match[1];
  assign sel_blk  = way_blk[hit_way];

  assign busywait_cpu = req & ~(idle & hit);
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

  always_comb begin
    READDATA_CPU = '0;
    if (idle && hit && READ_CPU && !WRITE_CPU) begin
      READDATA_CPU = sel_blk[cpu_off*WORD_W +: WORD_W];
    end
  end

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .OFFSET_W(OFFSET_W),
      .WORD_W  (WORD_W),
      .BLK_W   (BLK_W)
    ) u_way (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .rd_index (lk_index),
      .rd_tag   (cpu_tag),
      .match_o  (match[w]),
      .valid_o  (vld[w]),
      .dirty_o  (drt[w]),
      .tag_o    (way_tag[w]),
      .block_o  (way_blk[w]),
      .wr_en    (way_we[w]),
      .wr_fill  (way_fill),
      .wr_index (wr_index),
      .wr_tag   (req_tag_q),
      .wr_offset(cpu_off),
      .wr_word  (WRITEDATA_CPU),
      .wr_block (fill_q)
    );
  end

  always_comb begin
    state_d     = state_q;
    lru_d       = lru_q;
    victim_d    = victim_q;
    req_tag_d   = req_tag_q;
    req_index_d = req_index_q;
    fill_d      = fill_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    way_we      = '0;
    way_fill    = 1'b0;
    wr_index    = cpu_index;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_block_address = '0;
    mem_WriteData     = '0;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          lru_d[cpu_index] = ~hit_way;
          way_we[hit_way]  = WRITE_CPU;
          if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
        end else if (req) begin
          // Invalid ways are filled before anything is evicted.
          victim_d    = !vld[0] ? 1'b0 :
                        !vld[1] ? 1'b1 : lru_q[cpu_index];
          req_tag_d   = cpu_tag;
          req_index_d = cpu_index;
          if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
          state_d = (vld[victim_d] && drt[victim_d]) ?
                    WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        mem_write         = 1'b1;
        mem_block_address = {way_tag[victim_q], req_index_q};
        mem_WriteData     = way_blk[victim_q];
        if (!mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        mem_read          = 1'b1;
        mem_block_address = {req_tag_q, req_index_q};
        if (!mem_busywait) begin
          fill_d  = mem_ReadData;
          state_d = REFILL;
        end
      end
      REFILL: begin
        way_we[victim_q]   = 1'b1;
        way_fill           = 1'b1;
        wr_index           = req_index_q;
        lru_d[req_index_q] = ~victim_q;
        state_d            = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      lru_q       <= '0;
      victim_q    <= 1'b0;
      req_tag_q   <= '0;
      req_index_q <= '0;
      fill_q      <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lru_q       <= lru_d;
      victim_q    <= victim_d;
      req_tag_q   <= req_tag_d;
      req_index_q <= req_index_d;
      fill_q      <= fill_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: expected load data and memory
// transactions are queued at stimulus time and checked on arrival.
module tb_assoc_cache;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        READ_CPU, WRITE_CPU;
  logic [7:0]  cpu_address, WRITEDATA_CPU, READDATA_CPU;
  logic        busywait_cpu, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_block_address;
  logic [31:0] mem_WriteData, mem_ReadData;
  logic [15:0] hit_count, miss_count;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mop_t;

  mop_t        mq[$];
  logic [7:0]  rq[$];
  logic [31:0] mem [64];
  int          mem_lat;
  int          n_checks = 0;
  int          n_err = 0;

  assoc_cache dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .READ_CPU         (READ_CPU),
    .WRITE_CPU        (WRITE_CPU),
    .cpu_address      (cpu_address),
    .WRITEDATA_CPU    (WRITEDATA_CPU),
    .READDATA_CPU     (READDATA_CPU),
    .busywait_cpu     (busywait_cpu),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_block_address(mem_block_address),
    .mem_WriteData    (mem_WriteData),
    .mem_ReadData     (mem_ReadData),
    .mem_busywait     (mem_busywait),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Block memory: busy for mem_lat sampled edges per request.
  initial begin : mem_model
    logic        active, cur_wr;
    logic [5:0]  cur_addr;
    logic [31:0] cur_data;
    int          rem;
    mop_t        e;
    active = 1'b0; cur_wr = 1'b0; cur_addr = '0;
    cur_data = '0; rem = 0;
    mem_busywait = 1'b0;
    mem_ReadData = '0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        active = 1'b0;
        mem_busywait = 1'b0;
      end else if (!active) begin
        if (mem_read || mem_write) begin
          if (mq.size() == 0) begin
            check("mem_unexpected", 32'd1, 32'd0);
          end else begin
            e = mq.pop_front();
            check("mem_op", {31'b0, mem_write}, {31'b0, e.wr});
            check("mem_addr", {26'b0, mem_block_address},
                  {26'b0, e.addr});
            if (e.wr) check("mem_wdata", mem_WriteData, e.data);
          end
          active = 1'b1;
          cur_wr = mem_write;
          cur_addr = mem_block_address;
          cur_data = mem_WriteData;
          rem = mem_lat;
          mem_busywait = 1'b1;
        end
      end else begin
        check("mem_hold",
              {31'b0, cur_wr ? mem_write : mem_read}, 32'd1);
        rem--;
        if (rem == 0) begin
          mem_busywait = 1'b0;
          active = 1'b0;
          if (cur_wr) mem[cur_addr] = cur_data;
          else mem_ReadData = mem[cur_addr];
        end
      end
    end
  end

  task automatic access(
    input logic       rd,
    input logic       wr,
    input logic [7:0] a,
    input logic [7:0] wd,
    input logic [7:0] exp_rd,
    input int         exp_stall
  );
    int stalls;
    bit done;
    @(negedge CLK);
    READ_CPU = rd;
    WRITE_CPU = wr;
    cpu_address = a;
    WRITEDATA_CPU = wd;
    if (rd && !wr) rq.push_back(exp_rd);
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!busywait_cpu) done = 1'b1;
      else begin
        stalls++;
        @(negedge CLK);
      end
    end
    if (!done) begin
      check("access_timeout", 32'd0, 32'd1);
    end else begin
      if (rd && !wr)
        check("rdata", {24'b0, READDATA_CPU},
              {24'b0, rq.pop_front()});
      check("stall", stalls, exp_stall);
    end
    @(posedge CLK);
    #1;
    READ_CPU = 1'b0;
    WRITE_CPU = 1'b0;
  endtask

  task automatic wait_mem(input bit want_wr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      #1;
      seen = want_wr ? mem_write : mem_read;
    end
    if (!seen) check("mem_req_timeout", 32'd0, 32'd1);
  endtask

  function automatic mop_t mop(
    input logic        wr,
    input logic [5:0]  addr,
    input logic [31:0] data
  );
    mop_t m;
    m.wr = wr;
    m.addr = addr;
    m.data = data;
    return m;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int clean, dirty;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA0B0C000 | i;
    mem[1] = 32'hDDCCBBAA;
    mem[5] = 32'h44332211;
    mem[9] = 32'h88776655;
    mem_lat = 2;
    READ_CPU = 1'b0;
    WRITE_CPU = 1'b0;
    cpu_address = '0;
    WRITEDATA_CPU = '0;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", {26'b0, mem_block_address}, 32'd0);
    check("rst_mem_wdata", mem_WriteData, 32'd0);
    check("rst_rdata", {24'b0, READDATA_CPU}, 32'd0);
    check("rst_busy", {31'b0, busywait_cpu}, 32'd0);
    check("rst_hits", {16'b0, hit_count}, 32'd0);
    check("rst_miss", {16'b0, miss_count}, 32'd0);
    RESET_N = 1'b1;

    clean = mem_lat + 3;
    dirty = 2 * mem_lat + 4;
    mq.push_back(mop(1'b0, 6'h01, '0));
    access(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, clean);
    check("miss_1", {16'b0, miss_count}, 32'd1);
    check("hit_1", {16'b0, hit_count}, 32'd1);

    access(1'b0, 1'b1, 8'h06, 8'h55, 8'h00, 0);
    access(1'b1, 1'b0, 8'h06, 8'h00, 8'h55, 0);

    mq.push_back(mop(1'b0, 6'h05, '0));
    access(1'b1, 1'b0, 8'h14, 8'h00, 8'h11, clean);
    access(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 0);
    access(1'b1, 1'b0, 8'h17, 8'h00, 8'h44, 0);

    access(1'b1, 1'b0, 8'h14, 8'h00, 8'h11, 0);
    mq.push_back(mop(1'b1, 6'h01, 32'hDD55BBAA));
    mq.push_back(mop(1'b0, 6'h09, '0));
    access(1'b1, 1'b0, 8'h24, 8'h00, 8'h55, dirty);
    check("miss_3", {16'b0, miss_count}, 32'd3);
    check("hit_8", {16'b0, hit_count}, 32'd8);

    mem_lat = 5;
    clean = mem_lat + 3;
    mq.push_back(mop(1'b0, 6'h0D, '0));
    access(1'b1, 1'b0, 8'h34, 8'h00, 8'h0D, clean);

    @(negedge CLK);
    READ_CPU = 1'b1;
    cpu_address = 8'h44;
    mq.push_back(mop(1'b0, 6'h11, '0));
    wait_mem(1'b0);
    repeat (2) @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    check("rst_fetch_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_fetch_miss", {16'b0, miss_count}, 32'd0);
    READ_CPU = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    RESET_N = 1'b1;

    mq.push_back(mop(1'b0, 6'h01, '0));
    access(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, clean);
    check("post_rst_miss", {16'b0, miss_count}, 32'd1);

    access(1'b1, 1'b1, 8'h07, 8'h99, 8'h00, 0);
    access(1'b1, 1'b0, 8'h07, 8'h00, 8'h99, 0);
    mq.push_back(mop(1'b0, 6'h11, '0));
    access(1'b0, 1'b1, 8'h45, 8'h77, 8'h00, clean);
    access(1'b1, 1'b0, 8'h45, 8'h00, 8'h77, 0);
    access(1'b1, 1'b0, 8'h44, 8'h00, 8'h11, 0);
    check("miss_2", {16'b0, miss_count}, 32'd2);
    check("hit_6", {16'b0, hit_count}, 32'd6);

    @(negedge CLK);
    READ_CPU = 1'b1;
    cpu_address = 8'h84;
    mq.push_back(mop(1'b1, 6'h01, 32'h9955BBAA));
    mq.push_back(mop(1'b0, 6'h21, '0));
    wait_mem(1'b1);
    READ_CPU = 1'b0;
    repeat (25) @(negedge CLK);
    #1;
    check("drop_miss", {16'b0, miss_count}, 32'd3);
    check("drop_hit", {16'b0, hit_count}, 32'd6);
    check("drop_mq_empty", mq.size(), 32'd0);
    access(1'b1, 1'b0, 8'h84, 8'h00, 8'h21, 0);
    access(1'b1, 1'b0, 8'h44, 8'h00, 8'h11, 0);
    check("hit_8_end", {16'b0, hit_count}, 32'd8);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
